// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery BRAM width adapter.
// Optional feature: MONT_ADAPTER_WORD_SWAP_EN maps the first stream word to the
// most significant operand slot (big-endian word order) for pack and unpack.
package mont_pkg;

  localparam int RSA_BITS  = 1024;
  localparam int WORD_BITS = 32;
  localparam int NWORDS    = RSA_BITS / WORD_BITS;
  localparam int CNT_BITS  = $clog2(NWORDS);

  // Pack FSM: collect words, then one pulse cycle.
  typedef enum logic {
    P_FILL = 1'b0,
    P_EMIT = 1'b1
  } pstate_t;

  // Unpack FSM: wait for a result, then stream it out.
  typedef enum logic {
    U_IDLE  = 1'b0,
    U_DRAIN = 1'b1
  } ustate_t;

  // Wrapper command codes used by the sequencer that drives both halves.
  typedef enum logic [1:0] {
    CMD_READ    = 2'd0,
    CMD_COMPUTE = 2'd1,
    CMD_WRITE   = 2'd2
  } cmd_t;

  // Operand slot that holds stream word number idx. NWORDS is a power of two,
  // so the mirrored slot NWORDS-1-idx is simply the bitwise inverse.
  function automatic logic [CNT_BITS-1:0] slot_of(input logic [CNT_BITS-1:0] idx);
`ifdef MONT_ADAPTER_WORD_SWAP_EN
    return ~idx;
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/mont_bram_adapter_if.sv
// Bus bundle between the processor word streams and the Montgomery wrapper.
//
// Handshake rules: a stream word moves only on a clock edge where valid and
// ready are both high. A source that has raised valid keeps valid and data
// stable until the transfer happens; ready may change freely. The wrapper
// side is not a valid/ready pair: bram_din_valid and bram_dout_read are
// single-cycle pulses, bram_dout_valid is a level held until bram_dout_read.
interface mont_bram_adapter_if;
  import mont_pkg::*;

  logic [WORD_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [RSA_BITS-1:0]  bram_din;
  logic                 bram_din_valid;
  logic [RSA_BITS-1:0]  bram_dout;
  logic                 bram_dout_valid;
  logic                 bram_dout_read;
  logic [WORD_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  // System side: word producer/consumer and the wrapper.
  modport master (
    output s_data, s_valid, bram_dout, bram_dout_valid, m_ready,
    input  s_ready, bram_din, bram_din_valid, bram_dout_read, m_data, m_valid
  );

  // Adapter side.
  modport slave (
    input  s_data, s_valid, bram_dout, bram_dout_valid, m_ready,
    output s_ready, bram_din, bram_din_valid, bram_dout_read, m_data, m_valid
  );
endinterface

// File: rtl/mont_bram_unpacker.sv
// Unpack half: captures one RSA_BITS result from the wrapper and streams it
// out as WORD_BITS words. MONT_ADAPTER_WORD_SWAP_EN selects top-word-first.
module mont_bram_unpacker
  import mont_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RSA_BITS-1:0]  bram_dout,
  input  logic                 bram_dout_valid,
  output logic                 bram_dout_read,
  output logic [WORD_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output ustate_t              state
);

  ustate_t              u_state, u_next;
  logic [RSA_BITS-1:0]  shbuf;
  logic [CNT_BITS-1:0]  rcnt;
  logic                 capture;
  logic                 xfer;

  assign state = u_state;

`ifdef MONT_ADAPTER_WORD_SWAP_EN
  assign m_data = shbuf[RSA_BITS-1 -: WORD_BITS];
`else
  assign m_data = shbuf[WORD_BITS-1:0];
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) u_state <= U_IDLE;
    else       u_state <= u_next;
  end

  // Next state and handshake decode; bram_dout_valid is ignored while draining.
  always_comb begin
    u_next  = u_state;
    m_valid = 1'b0;
    capture = 1'b0;
    xfer    = 1'b0;
    case (u_state)
      U_IDLE: begin
        if (bram_dout_valid) begin
          capture = 1'b1;
          u_next  = U_DRAIN;
        end
      end
      U_DRAIN: begin
        m_valid = 1'b1;
        if (m_ready) begin
          xfer = 1'b1;
          if (&rcnt) u_next = U_IDLE;
        end
      end
      default: u_next = U_IDLE;
    endcase
  end

  // Result buffer, word counter and the one-cycle read acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shbuf          <= '0;
      rcnt           <= '0;
      bram_dout_read <= 1'b0;
    end else begin
      bram_dout_read <= capture;
      if (capture) begin
        shbuf <= bram_dout;
        rcnt  <= '0;
      end else if (xfer) begin
`ifdef MONT_ADAPTER_WORD_SWAP_EN
        shbuf <= {shbuf[RSA_BITS-WORD_BITS-1:0], {WORD_BITS{1'b0}}};
`else
        shbuf <= {{WORD_BITS{1'b0}}, shbuf[RSA_BITS-1:WORD_BITS]};
`endif
        rcnt  <= rcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mont_bram_adapter.sv
// Width adapter between the 32-bit word streams and the RSA_BITS-wide BRAM
// ports of the Montgomery wrapper. The pack half lives here; the unpack half
// is mont_bram_unpacker. Both run independently.
// Optional feature: MONT_ADAPTER_WORD_SWAP_EN (big-endian word order).
module mont_bram_adapter
  import mont_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mont_bram_adapter_if.slave  bus,
  output pstate_t             pack_state,
  output ustate_t             unpack_state
);

  pstate_t              p_state, p_next;
  logic [CNT_BITS-1:0]  wcnt;
  logic [RSA_BITS-1:0]  din_q;
  logic                 accept;
  logic                 s_ready_c;
  logic                 din_valid_c;

  assign pack_state         = p_state;
  assign bus.s_ready        = s_ready_c;
  assign bus.bram_din_valid = din_valid_c;
  assign bus.bram_din       = din_q;
  assign accept             = bus.s_valid && s_ready_c;

  // Pack state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_state <= P_FILL;
    else       p_state <= p_next;
  end

  // Pack next state and outputs; the emit cycle is the only one not ready.
  always_comb begin
    p_next      = p_state;
    s_ready_c   = 1'b0;
    din_valid_c = 1'b0;
    case (p_state)
      P_FILL: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && (&wcnt)) p_next = P_EMIT;
      end
      P_EMIT: begin
        din_valid_c = 1'b1;
        p_next      = P_FILL;
      end
      default: p_next = P_FILL;
    endcase
  end

  // Operand assembly: each accepted word lands in its slot; old slots persist
  // until overwritten, so bram_din stays put after the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_q <= '0;
      wcnt  <= '0;
    end else if (accept) begin
      din_q[int'(slot_of(wcnt)) * WORD_BITS +: WORD_BITS] <= bus.s_data;
      wcnt <= wcnt + 1'b1;
    end
  end

  mont_bram_unpacker u_unpack (
    .clk             (clk),
    .reset           (reset),
    .bram_dout       (bus.bram_dout),
    .bram_dout_valid (bus.bram_dout_valid),
    .bram_dout_read  (bus.bram_dout_read),
    .m_data          (bus.m_data),
    .m_valid         (bus.m_valid),
    .m_ready         (bus.m_ready),
    .state           (unpack_state)
  );

endmodule

// File: tb/tb_mont_bram_adapter.sv
// Bench for mont_bram_adapter. The reference model works on whole operands:
// it queues accepted words and assembles an operand every NWORDS words, and
// it expands each captured result into a queue of expected output words.
module tb_mont_bram_adapter;
  import mont_pkg::*;

  localparam int NW = NWORDS;
  localparam int WB = WORD_BITS;

  logic    clk = 1'b0;
  logic    reset;
  pstate_t pack_state;
  ustate_t unpack_state;

  mont_bram_adapter_if bus();

  mont_bram_adapter dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pack_state   (pack_state),
    .unpack_state (unpack_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_din_valid"}, 32'(bus.bram_din_valid), 32'd0);
    check({tag, "_m_valid"},   32'(bus.m_valid),        32'd0);
    check({tag, "_dout_read"}, 32'(bus.bram_dout_read), 32'd0);
    check({tag, "_s_ready"},   32'(bus.s_ready),        32'd1);
    check({tag, "_din_zero"},  32'(|bus.bram_din),      32'd0);
    check({tag, "_m_data"},    bus.m_data,              32'd0);
    check({tag, "_pstate"},    32'(pack_state),         32'(P_FILL));
    check({tag, "_ustate"},    32'(unpack_state),       32'(U_IDLE));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.bram_dout_valid = 1'b0;
    #12;
    check_idle("rst_during");
    #13;
    reset = 1'b0;
    #1;
    check_idle("rst_after");
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [WB-1:0] acc_q[$];
  logic [WB-1:0] exp_op[NW];
  logic [WB-1:0] exp_q[$];
  bit            pend = 1'b0;
  bit            new_pend;
  bit            exp_read = 1'b0;
  bit            busy;

  always @(negedge clk) begin
    if (reset) begin
      acc_q.delete();
      exp_q.delete();
      pend     = 1'b0;
      exp_read = 1'b0;
    end else begin
      // pack: ready except in the cycle after the NWORDS-th accepted word
      check("s_ready", 32'(bus.s_ready), 32'(!pend));
      if (bus.bram_din_valid || pend)
        check("din_valid", 32'(bus.bram_din_valid), 32'(pend));
      if (pend)
        for (int k = 0; k < NW; k++)
          check("din_slot", bus.bram_din[k*WB +: WB], exp_op[k]);
      new_pend = 1'b0;
      if (bus.s_valid && !pend) begin
        acc_q.push_back(bus.s_data);
        if (acc_q.size() == NW) begin
          for (int k = 0; k < NW; k++) begin
`ifdef MONT_ADAPTER_WORD_SWAP_EN
            exp_op[NW-1-k] = acc_q[k];
`else
            exp_op[k] = acc_q[k];
`endif
          end
          acc_q.delete();
          new_pend = 1'b1;
        end
      end
      pend = new_pend;

      // unpack: words of the current result are emitted in order
      busy = (exp_q.size() != 0);
      check("m_valid", 32'(bus.m_valid), 32'(busy));
      if (bus.bram_dout_read || exp_read)
        check("dout_read", 32'(bus.bram_dout_read), 32'(exp_read));
      exp_read = 1'b0;
      if (busy) begin
        check("m_data", bus.m_data, exp_q[0]);
        if (bus.m_ready) void'(exp_q.pop_front());
      end else if (bus.bram_dout_valid) begin
        for (int k = 0; k < NW; k++) begin
`ifdef MONT_ADAPTER_WORD_SWAP_EN
          exp_q.push_back(bus.bram_dout[(NW-1-k)*WB +: WB]);
`else
          exp_q.push_back(bus.bram_dout[k*WB +: WB]);
`endif
        end
        exp_read = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: continuous, 1: idle cycle after each word, 2: random gaps
  task automatic send_words(input logic [31:0] base, input int n, input int mode, input bit rnd);
    bit got;
    for (int i = 0; i < n; i++) begin
      if (mode == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.s_data  = rnd ? $urandom : base + 32'(i);
      bus.s_valid = 1'b1;
      got = 1'b0;
      for (int g = 0; g < 50 && !got; g++) begin
        @(negedge clk);
        got = bus.s_ready;
        @(posedge clk); #1;
      end
      if (!got) check("s_timeout", 32'd0, 32'd1);
      bus.s_valid = 1'b0;
      if (mode == 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic push_result(input logic [RSA_BITS-1:0] v);
    bit got;
    bus.bram_dout = v;
    bus.bram_dout_valid = 1'b1;
    got = 1'b0;
    for (int g = 0; g < 200 && !got; g++) begin
      @(negedge clk);
      got = bus.bram_dout_read;
    end
    if (!got) check("read_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.bram_dout_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int g = 0; g < 400 && !done; g++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !exp_read;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [RSA_BITS-1:0] rand_op();
    logic [RSA_BITS-1:0] r;
    for (int k = 0; k < NW; k++) r[k*WB +: WB] = $urandom;
    return r;
  endfunction

  // consumer ready: 0 always, 1 every other cycle, 2 random
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = !bus.m_ready;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- test sequence ----------------
  logic [RSA_BITS-1:0] a5_op;

  initial begin
    reset = 1'b1;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.bram_dout = '0;
    bus.bram_dout_valid = 1'b0;
    do_reset();

    // pack, continuous words 0..31
    settle(1);
    send_words(32'h0, NW, 0, 1'b0);
    settle(3);

    // pack with s_valid toggling
    send_words(32'h0, NW, 1, 1'b0);
    settle(3);

    // unpack with alternate-cycle backpressure
    rdy_mode = 1;
    for (int k = 0; k < NW; k++) a5_op[k*WB +: WB] = 32'hA500_0000 + 32'(k);
    push_result(a5_op);
    wait_drain();
    settle(2);

    // reset in the middle of a fill
    rdy_mode = 0;
    send_words(32'hC000_0000, 10, 0, 1'b0);
    do_reset();
    settle(1);
    send_words(32'hB000_0000, NW, 0, 1'b0);
    settle(3);

    // concurrent pack and unpack with random data, gaps and backpressure
    rdy_mode = 2;
    for (int it = 0; it < 4; it++) begin
      fork
        send_words(32'h0, NW, 2, 1'b1);
        begin
          push_result(rand_op());
          wait_drain();
          push_result(rand_op());
          wait_drain();
        end
      join
      settle(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #400000;
    check("watchdog", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mont_bram_adapter.md
Name: mont_bram_adapter

Overview:
- Width adapter between the 32-bit processor-side word stream and the RSA_BITS-wide BRAM ports of the Montgomery wrapper.
- Pack half: collects NWORDS input words into one operand, then pulses it onto the wrapper's bram_din.
- Unpack half: captures the wrapper's bram_dout result and streams it back out as 32-bit words.
- The two halves are independent and operate concurrently.

Parameters:
- RSA_BITS, 1024, operand width in bits.
- WORD_BITS, 32, stream word width.
- NWORDS, RSA_BITS/WORD_BITS (32), words per operand. Derived; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  WORD_BITS  input word.
- s_valid  in  1  input word valid.
- s_ready  out  1  adapter can accept a word.
- bram_din  out  RSA_BITS  packed operand to the wrapper.
- bram_din_valid  out  1  one-cycle pulse; bram_din is valid.
- bram_dout  in  RSA_BITS  result from the wrapper.
- bram_dout_valid  in  1  wrapper has a result pending.
- bram_dout_read  out  1  one-cycle pulse acknowledging capture of bram_dout.
- m_data  out  WORD_BITS  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system):
  - Outputs: bram_din=0, bram_din_valid=0, bram_dout_read=0, m_data=0, m_valid=0, s_ready=1.
  - Both FSMs go to their idle state; both counters = 0.
  - Reset mid-operation discards partial words and any undrained result. No pulse is generated.
- Handshakes:
  - Input accepted only when s_valid & s_ready.
  - Output transferred only when m_valid & m_ready.
  - m_data/m_valid stay stable while m_valid & !m_ready.
- Pack FSM:
  - P_FILL: s_ready=1. Each accept writes s_data into word slot wcnt (slot k = bits [32k+31:32k]) and increments wcnt (log2(NWORDS) bits).
    - Accept with wcnt=NWORDS-1: wcnt wraps to 0; go to P_EMIT.
  - P_EMIT: lasts exactly one cycle. bram_din_valid=1, s_ready=0. Next state is P_FILL.
  - Latency: bram_din_valid is high the cycle after the last word's handshake.
  - bram_din holds its value until the first accept of the next operand overwrites slot 0.
- Unpack FSM:
  - U_IDLE: m_valid=0. If bram_dout_valid=1: register bram_dout into a shift buffer, pulse bram_dout_read=1 for the next cycle only, set rcnt=0, go to U_DRAIN.
  - U_DRAIN: m_valid=1, m_data=buffer word 0.
    - Each transfer shifts the buffer right by WORD_BITS and increments rcnt.
    - Transfer with rcnt=NWORDS-1: go to U_IDLE; m_valid=0 the next cycle.
  - bram_dout_valid is ignored in U_DRAIN: no read pulse, no capture.
  - First m_valid appears 1 cycle after bram_dout_valid is sampled high.
  - A new capture is possible in the cycle after returning to U_IDLE. bram_dout_valid still high then is treated as a new result; the wrapper deasserts it on bram_dout_read.
- Simultaneous events: pack and unpack never stall each other. Both may be active in the same cycle.
- No arithmetic beyond the counters. Counters wrap modulo NWORDS.

Optional Feature:
- Macro: MONT_ADAPTER_WORD_SWAP_EN.
- Defined: the first stream word maps to the most significant slot (slot NWORDS-1), for both pack and unpack. Unpack shifts left and emits the top word first.
- Undefined: little-endian word order as described in Behaviour.
- Word-internal bit order is unchanged in both modes.

Decomposition:
- Shared package mont_pkg holds:
  - RSA_BITS, WORD_BITS, NWORDS.
  - Pack and unpack state enums (P_FILL/P_EMIT, U_IDLE/U_DRAIN).
  - Wrapper command codes CMD_READ=0, CMD_COMPUTE=1, CMD_WRITE=2, for the sequencer that drives both blocks.
- The unpack half is a natural sub-module, mont_bram_unpacker. The pack half stays in the top.

Test Plan:
- Reset: hold reset 25 ns, check outputs during and after reset → bram_din_valid=0, m_valid=0, bram_dout_read=0, s_ready=1, bram_din=0.
- Pack, continuous s_valid: send words 0x00000000..0x0000001F → one bram_din_valid pulse in the cycle after the 32nd handshake; bram_din slot k = k; s_ready=0 in that cycle only.
- Pack with gaps: same 32 words, s_valid toggled 1/0 → identical bram_din. wcnt advances only on handshakes.
- Unpack with backpressure: bram_dout slot k = 0xA5000000+k, bram_dout_valid held high until read; m_ready high every other cycle → exactly one bram_dout_read pulse; m_data sequence 0xA5000000..0xA500001F with no repeats or drops; m_valid low after word 31.
- Reset mid-fill: after 10 words assert reset, then send 32 words 0xB0000000+k → bram_din contains only the new words; exactly one pulse.
- Concurrent pack/unpack, repeated with MONT_ADAPTER_WORD_SWAP_EN defined:
  - Run the pack and unpack streams simultaneously → both complete independently.
  - With the swap macro, the first input word lands in bram_din[1023:992], and the first output word is bram_dout[1023:992].
